// File: rtl/dmem_lane_arbiter.sv
// Two-port round-robin front end for four byte-lane data BRAMs: steers (possibly misaligned)
// byte/half/word accesses across lanes in one cycle and returns extended load data.
module dmem_lane_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        P0_REQ_VALID,
    output logic                        P0_REQ_READY,
    input  logic                        P0_REQ_WE,
    input  logic [1:0]                  P0_REQ_SIZE,
    input  logic                        P0_REQ_UNSIGNED,
    input  logic [ADDR_WIDTH-1:0]       P0_REQ_ADDR,
    input  logic [31:0]                 P0_REQ_WDATA,
    output logic                        P0_RSP_VALID,
    input  logic                        P1_REQ_VALID,
    output logic                        P1_REQ_READY,
    input  logic                        P1_REQ_WE,
    input  logic [1:0]                  P1_REQ_SIZE,
    input  logic                        P1_REQ_UNSIGNED,
    input  logic [ADDR_WIDTH-1:0]       P1_REQ_ADDR,
    input  logic [31:0]                 P1_REQ_WDATA,
    output logic                        P1_RSP_VALID,
    output logic [31:0]                 RSP_RDATA,
    output logic [4*(ADDR_WIDTH-2)-1:0] LANE_W_ADDR,
    output logic [4*(ADDR_WIDTH-2)-1:0] LANE_R_ADDR,
    output logic [3:0]                  LANE_WE,
    output logic [3:0]                  LANE_RE,
    output logic [31:0]                 LANE_DIN,
    input  logic [31:0]                 LANE_DOUT
);

    localparam int unsigned WordW = ADDR_WIDTH - 2;

    logic       last_q, last_d;
    logic       rsp_pend_q, rsp_pend_d;
    logic       rsp_port_q, rsp_port_d;
    logic [1:0] rsp_size_q, rsp_size_d;
    logic       rsp_uns_q, rsp_uns_d;
    logic [1:0] rsp_a_q, rsp_a_d;

    logic                  grant0, grant1, accept, sel;
    logic                  req_we, req_uns;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [2:0]            req_nbytes;

    // last_q holds the most recent winner; on a tie the other port wins
    always_comb begin
        grant0       = P0_REQ_VALID & (~P1_REQ_VALID | last_q);
        grant1       = P1_REQ_VALID & (~P0_REQ_VALID | ~last_q);
        P0_REQ_READY = grant0 & RST_N;
        P1_REQ_READY = grant1 & RST_N;
        accept       = P0_REQ_READY | P1_REQ_READY;
        sel          = P1_REQ_READY;
        if (sel) begin
            req_we    = P1_REQ_WE;
            req_uns   = P1_REQ_UNSIGNED;
            req_size  = P1_REQ_SIZE;
            req_addr  = P1_REQ_ADDR;
            req_wdata = P1_REQ_WDATA;
        end else begin
            req_we    = P0_REQ_WE;
            req_uns   = P0_REQ_UNSIGNED;
            req_size  = P0_REQ_SIZE;
            req_addr  = P0_REQ_ADDR;
            req_wdata = P0_REQ_WDATA;
        end
        case (req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    logic [1:0]       lane_k    [4];
    logic [3:0]       lane_hit;
    logic [WordW-1:0] lane_word [4];

    // lane_k is the request byte landing on this lane; lanes below A[1:0] belong to the next word
    always_comb begin
        LANE_W_ADDR = '0;
        LANE_R_ADDR = '0;
        LANE_WE     = '0;
        LANE_RE     = '0;
        LANE_DIN    = '0;
        lane_hit    = '0;
        for (int l = 0; l < 4; l++) begin
            lane_k[l]    = 2'(l) - req_addr[1:0];
            lane_hit[l]  = {1'b0, lane_k[l]} < req_nbytes;
            lane_word[l] = req_addr[ADDR_WIDTH-1:2];
            if (lane_hit[l] && (2'(l) < req_addr[1:0])) begin
                lane_word[l] = lane_word[l] + WordW'(1);
            end
            LANE_W_ADDR[l*WordW +: WordW] = lane_word[l];
            LANE_R_ADDR[l*WordW +: WordW] = lane_word[l];
            LANE_WE[l] = accept & req_we & lane_hit[l];
            LANE_RE[l] = accept & ~req_we & lane_hit[l];
            LANE_DIN[l*8 +: 8] = lane_hit[l] ? req_wdata[{lane_k[l], 3'b000} +: 8] : 8'h00;
        end
    end

    always_comb begin
        last_d     = accept ? sel : last_q;
        rsp_pend_d = accept & ~req_we;
        rsp_port_d = rsp_port_q;
        rsp_size_d = rsp_size_q;
        rsp_uns_d  = rsp_uns_q;
        rsp_a_d    = rsp_a_q;
        if (accept && !req_we) begin
            rsp_port_d = sel;
            rsp_size_d = (req_size == 2'b11) ? 2'b10 : req_size;
            rsp_uns_d  = req_uns;
            rsp_a_d    = req_addr[1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q     <= 1'b1;
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
            rsp_size_q <= 2'b00;
            rsp_uns_q  <= 1'b0;
            rsp_a_q    <= 2'b00;
        end else begin
            last_q     <= last_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_port_q <= rsp_port_d;
            rsp_size_q <= rsp_size_d;
            rsp_uns_q  <= rsp_uns_d;
            rsp_a_q    <= rsp_a_d;
        end
    end

    logic [7:0]  rd_byte [4];
    logic [31:0] rd_ext;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_byte[k] = LANE_DOUT[{rsp_a_q + 2'(k), 3'b000} +: 8];
        end
        case (rsp_size_q)
            2'b00:   rd_ext = {{24{~rsp_uns_q & rd_byte[0][7]}}, rd_byte[0]};
            2'b01:   rd_ext = {{16{~rsp_uns_q & rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            default: rd_ext = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        endcase
        RSP_RDATA    = rsp_pend_q ? rd_ext : 32'h0;
        P0_RSP_VALID = rsp_pend_q & ~rsp_port_q;
        P1_RSP_VALID = rsp_pend_q & rsp_port_q;
    end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Bench for dmem_lane_arbiter: a byte-addressed reference memory predicts lane steering,
// arbitration order and load results; a four-lane BRAM model serves LANE_DOUT.
module tb_dmem_lane_arbiter;

    localparam int AW = 8;
    localparam int WW = AW - 2;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic preload = 1'b1;

    logic [1:0]        req_valid = '0;
    logic [1:0]        req_we = '0;
    logic [1:0]        req_uns = '0;
    logic [1:0][1:0]   req_size = '0;
    logic [1:0][AW-1:0] req_addr = '0;
    logic [1:0][31:0]  req_wdata = '0;

    logic p0_ready, p1_ready, p0_rsp, p1_rsp;
    logic [31:0]     rdata, lane_din;
    logic [31:0]     lane_dout = '0;
    logic [4*WW-1:0] w_addr, r_addr;
    logic [3:0]      lane_we, lane_re;

    logic [7:0] ref_mem  [256];
    logic [7:0] lane_mem [4][64];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  model_last = 1'b1;

    always #5 CLK = ~CLK;

    dmem_lane_arbiter #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .P0_REQ_VALID(req_valid[0]), .P0_REQ_READY(p0_ready), .P0_REQ_WE(req_we[0]),
        .P0_REQ_SIZE(req_size[0]), .P0_REQ_UNSIGNED(req_uns[0]), .P0_REQ_ADDR(req_addr[0]),
        .P0_REQ_WDATA(req_wdata[0]), .P0_RSP_VALID(p0_rsp),
        .P1_REQ_VALID(req_valid[1]), .P1_REQ_READY(p1_ready), .P1_REQ_WE(req_we[1]),
        .P1_REQ_SIZE(req_size[1]), .P1_REQ_UNSIGNED(req_uns[1]), .P1_REQ_ADDR(req_addr[1]),
        .P1_REQ_WDATA(req_wdata[1]), .P1_RSP_VALID(p1_rsp),
        .RSP_RDATA(rdata), .LANE_W_ADDR(w_addr), .LANE_R_ADDR(r_addr),
        .LANE_WE(lane_we), .LANE_RE(lane_re), .LANE_DIN(lane_din), .LANE_DOUT(lane_dout)
    );

    // Four byte-wide BRAMs with registered read, preloaded from the reference image
    always @(posedge CLK) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) lane_mem[a % 4][a / 4] <= ref_mem[a];
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (lane_we[l]) lane_mem[l][w_addr[l*WW +: WW]] <= lane_din[l*8 +: 8];
                if (lane_re[l]) lane_dout[l*8 +: 8] <= lane_mem[l][r_addr[l*WW +: WW]];
            end
        end
    end

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(logic [7:0] a, logic [1:0] sz, bit uns);
        logic [31:0] v = 0;
        logic [7:0]  b;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) begin
            b = ref_mem[8'(a + k)];
            v = v + (32'(b) << (8 * k));
        end
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] exp_mask(logic [7:0] a, logic [1:0] sz);
        logic [3:0] m = '0;
        for (int k = 0; k < nbytes(sz); k++) m[(a + k) % 4] = 1'b1;
        return m;
    endfunction

    function automatic logic [4*WW-1:0] exp_addrs(logic [7:0] a, logic [1:0] sz);
        logic [4*WW-1:0] r;
        logic [7:0] aa;
        for (int l = 0; l < 4; l++) r[l*WW +: WW] = WW'(a >> 2);
        for (int k = 0; k < nbytes(sz); k++) begin
            aa = 8'(a + k);
            r[(aa % 4)*WW +: WW] = WW'(aa >> 2);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_din(logic [7:0] a, logic [1:0] sz, logic [31:0] wd);
        logic [31:0] d = '0;
        for (int k = 0; k < nbytes(sz); k++) d[((a + k) % 4)*8 +: 8] = wd[k*8 +: 8];
        return d;
    endfunction

    task automatic ref_store(logic [7:0] a, logic [1:0] sz, logic [31:0] wd);
        for (int k = 0; k < nbytes(sz); k++) ref_mem[8'(a + k)] = wd[k*8 +: 8];
    endtask

    task automatic set_req(int p, bit we, logic [1:0] sz, bit uns, logic [7:0] a,
                           logic [31:0] wd);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_size[p]  = sz;
        req_uns[p]   = uns;
        req_addr[p]  = a;
        req_wdata[p] = wd;
    endtask

    task automatic clear_req();
        req_valid = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        set_req(0, 0, 2'b10, 0, 8'h00, 0);
        set_req(1, 0, 2'b10, 0, 8'h04, 0);
        @(negedge CLK);
        n_checks++; if ({p1_ready, p0_ready} !== 2'b00) begin n_errors++;
            $display("FAIL reset_ready got %b exp 00", {p1_ready, p0_ready}); end
        n_checks++; if ({p1_rsp, p0_rsp} !== 2'b00) begin n_errors++;
            $display("FAIL reset_rsp got %b exp 00", {p1_rsp, p0_rsp}); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++;
            $display("FAIL reset_rdata got %h exp 0", rdata); end
        n_checks++; if (lane_we !== 4'h0) begin n_errors++;
            $display("FAIL reset_we got %b exp 0000", lane_we); end
        n_checks++; if (lane_re !== 4'h0) begin n_errors++;
            $display("FAIL reset_re got %b exp 0000", lane_re); end
        clear_req();
        tick();
        preload = 1'b0;
        RST_N = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_word_store();
        set_req(0, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF);
        @(negedge CLK);
        n_checks++; if ({p1_ready, p0_ready} !== 2'b01) begin n_errors++;
            $display("FAIL ws_ready got %b exp 01", {p1_ready, p0_ready}); end
        n_checks++; if (lane_we !== 4'hF || lane_re !== 4'h0) begin n_errors++;
            $display("FAIL ws_en got we=%b re=%b exp we=1111 re=0000", lane_we, lane_re); end
        n_checks++; if (w_addr !== {4{6'd4}}) begin n_errors++;
            $display("FAIL ws_addr got %h exp %h", w_addr, {4{6'd4}}); end
        n_checks++; if (lane_din !== 32'hDEADBEEF) begin n_errors++;
            $display("FAIL ws_din got %h exp deadbeef", lane_din); end
        tick();
        ref_store(8'h10, 2'b10, 32'hDEADBEEF);
        model_last = 1'b0;
        clear_req();
        for (int u = 0; u < 2; u++) begin
            set_req(0, 0, 2'b00, u[0], 8'h13, 0);
            @(negedge CLK);
            n_checks++; if (lane_re !== 4'b1000 || r_addr[3*WW +: WW] !== 6'd4) begin
                n_errors++;
                $display("FAIL lb_steer got re=%b a3=%0d exp re=1000 a3=4", lane_re,
                         r_addr[3*WW +: WW]); end
            tick();
            clear_req();
            @(negedge CLK);
            n_checks++; if ({p1_rsp, p0_rsp} !== 2'b01) begin n_errors++;
                $display("FAIL lb_rsp got %b exp 01", {p1_rsp, p0_rsp}); end
            n_checks++; if (rdata !== (u ? 32'h000000DE : 32'hFFFFFFDE)) begin n_errors++;
                $display("FAIL lb_data uns=%0d got %h exp %h", u, rdata,
                         u ? 32'h000000DE : 32'hFFFFFFDE); end
            n_checks++; if (lane_re !== 4'h0) begin n_errors++;
                $display("FAIL idle_re got %b exp 0000", lane_re); end
            tick();
        end
    endtask

    task automatic test_misaligned_half();
        set_req(1, 1, 2'b01, 0, 8'h07, 32'h00001234);
        @(negedge CLK);
        n_checks++; if ({p1_ready, p0_ready} !== 2'b10) begin n_errors++;
            $display("FAIL mh_ready got %b exp 10", {p1_ready, p0_ready}); end
        n_checks++; if (lane_we !== 4'b1001) begin n_errors++;
            $display("FAIL mh_we got %b exp 1001", lane_we); end
        n_checks++; if (w_addr[3*WW +: WW] !== 6'd1 || w_addr[0 +: WW] !== 6'd2) begin
            n_errors++;
            $display("FAIL mh_addr got l3=%0d l0=%0d exp l3=1 l0=2", w_addr[3*WW +: WW],
                     w_addr[0 +: WW]); end
        n_checks++; if (lane_din[31:24] !== 8'h34 || lane_din[7:0] !== 8'h12) begin
            n_errors++;
            $display("FAIL mh_din got l3=%h l0=%h exp l3=34 l0=12", lane_din[31:24],
                     lane_din[7:0]); end
        tick();
        ref_store(8'h07, 2'b01, 32'h00001234);
        model_last = 1'b1;
        clear_req();
        set_req(1, 0, 2'b01, 1, 8'h07, 0);
        tick();
        clear_req();
        @(negedge CLK);
        n_checks++; if ({p1_rsp, p0_rsp} !== 2'b10) begin n_errors++;
            $display("FAIL mh_rsp got %b exp 10", {p1_rsp, p0_rsp}); end
        n_checks++; if (rdata !== 32'h00001234) begin n_errors++;
            $display("FAIL mh_data got %h exp 00001234", rdata); end
        tick();
    endtask

    // Both ports hold VALID with back-to-back loads; winners must alternate
    task automatic test_fairness();
        bit          prev_port = 0;
        logic [31:0] prev_data = 0;
        bit          exp_port;
        logic [7:0]  a [2];
        logic [1:0]  sz [2];
        bit          un [2];
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 2; p++) begin
                a[p]  = 8'($urandom);
                sz[p] = 2'($urandom);
                un[p] = 1'($urandom);
                set_req(p, 0, sz[p], un[p], a[p], 0);
            end
            exp_port = ~model_last;
            @(negedge CLK);
            n_checks++; if ({p1_ready, p0_ready} !== (exp_port ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("FAIL fair_grant%0d got %b exp P%0d", i, {p1_ready, p0_ready},
                         exp_port); end
            if (i > 0) begin
                n_checks++; if ({p1_rsp, p0_rsp} !== (prev_port ? 2'b10 : 2'b01) ||
                                rdata !== prev_data) begin
                    n_errors++;
                    $display("FAIL fair_rsp%0d got v=%b d=%h exp P%0d d=%h", i,
                             {p1_rsp, p0_rsp}, rdata, prev_port, prev_data); end
            end
            prev_port  = exp_port;
            prev_data  = ref_load(a[exp_port], sz[exp_port], un[exp_port]);
            model_last = exp_port;
            tick();
        end
        clear_req();
        @(negedge CLK);
        n_checks++; if ({p1_rsp, p0_rsp} !== 2'b10 || rdata !== prev_data) begin
            n_errors++;
            $display("FAIL fair_rsp_last got v=%b d=%h exp P1 d=%h", {p1_rsp, p0_rsp},
                     rdata, prev_data); end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w;
        set_req(0, 0, 2'b10, 0, 8'hFE, 0);
        @(negedge CLK);
        n_checks++; if (lane_re !== 4'hF) begin n_errors++;
            $display("FAIL wrap_re got %b exp 1111", lane_re); end
        n_checks++; if (r_addr !== {6'd63, 6'd63, 6'd0, 6'd0}) begin n_errors++;
            $display("FAIL wrap_addr got %h exp %h", r_addr, {6'd63, 6'd63, 6'd0, 6'd0}); end
        tick();
        model_last = 1'b0;
        clear_req();
        exp_w = {ref_mem[8'h01], ref_mem[8'h00], ref_mem[8'hFF], ref_mem[8'hFE]};
        @(negedge CLK);
        n_checks++; if (rdata !== exp_w || p0_rsp !== 1'b1) begin n_errors++;
            $display("FAIL wrap_data got v=%b d=%h exp v=1 d=%h", p0_rsp, rdata, exp_w); end
        tick();
    endtask

    task automatic test_size11();
        set_req(0, 0, 2'b11, 0, 8'h10, 0);
        tick();
        model_last = 1'b0;
        clear_req();
        @(negedge CLK);
        n_checks++; if (rdata !== 32'hDEADBEEF || {p1_rsp, p0_rsp} !== 2'b01) begin
            n_errors++;
            $display("FAIL size11 got v=%b d=%h exp v=01 d=deadbeef", {p1_rsp, p0_rsp},
                     rdata); end
        tick();
    endtask

    task automatic test_reset_midop();
        logic [31:0] exp_d;
        set_req(0, 0, 2'b10, 0, 8'h20, 0);
        tick();
        clear_req();
        RST_N = 1'b0;
        @(negedge CLK);
        n_checks++; if ({p1_rsp, p0_rsp} !== 2'b00 || rdata !== 32'h0) begin n_errors++;
            $display("FAIL rst_drop got v=%b d=%h exp v=00 d=0", {p1_rsp, p0_rsp}, rdata); end
        tick();
        RST_N = 1'b1;
        set_req(0, 0, 2'b10, 1, 8'h30, 0);
        set_req(1, 0, 2'b10, 1, 8'h40, 0);
        @(negedge CLK);
        n_checks++; if ({p1_rsp, p0_rsp} !== 2'b00) begin n_errors++;
            $display("FAIL rst_norsp got %b exp 00", {p1_rsp, p0_rsp}); end
        n_checks++; if ({p1_ready, p0_ready} !== 2'b01) begin n_errors++;
            $display("FAIL rst_tie got %b exp 01", {p1_ready, p0_ready}); end
        exp_d = ref_load(8'h30, 2'b10, 1);
        tick();
        model_last = 1'b0;
        clear_req();
        @(negedge CLK);
        n_checks++; if ({p1_rsp, p0_rsp} !== 2'b01 || rdata !== exp_d) begin n_errors++;
            $display("FAIL rst_after got v=%b d=%h exp v=01 d=%h", {p1_rsp, p0_rsp},
                     rdata, exp_d); end
        tick();
    endtask

    task automatic test_random();
        bit          pend = 0, pend_port = 0, acc, g;
        logic [31:0] pend_data = 0;
        logic [7:0]  a [2];
        logic [1:0]  sz [2];
        bit          un [2], we [2];
        logic [31:0] wd [2];
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                a[p]  = 8'($urandom);
                sz[p] = 2'($urandom);
                un[p] = 1'($urandom);
                we[p] = ($urandom_range(0, 2) == 0);
                wd[p] = $urandom;
                set_req(p, we[p], sz[p], un[p], a[p], wd[p]);
                req_valid[p] = 1'($urandom);
            end
            acc = req_valid[0] | req_valid[1];
            g   = (req_valid == 2'b11) ? ~model_last : req_valid[1];
            @(negedge CLK);
            n_checks++; if ({p1_ready, p0_ready} !== (acc ? (g ? 2'b10 : 2'b01) : 2'b00))
            begin
                n_errors++;
                $display("FAIL rnd_grant c=%0d got %b valid=%b last=%0d", c,
                         {p1_ready, p0_ready}, req_valid, model_last); end
            n_checks++; if ({p1_rsp, p0_rsp} !== (pend ? (pend_port ? 2'b10 : 2'b01) : 2'b00)
                            || rdata !== (pend ? pend_data : 32'h0)) begin
                n_errors++;
                $display("FAIL rnd_rsp c=%0d got v=%b d=%h exp pend=%0d P%0d d=%h", c,
                         {p1_rsp, p0_rsp}, rdata, pend, pend_port, pend_data); end
            if (acc) begin
                n_checks++;
                if (lane_we !== (we[g] ? exp_mask(a[g], sz[g]) : 4'h0) ||
                    lane_re !== (we[g] ? 4'h0 : exp_mask(a[g], sz[g]))) begin
                    n_errors++;
                    $display("FAIL rnd_en c=%0d got we=%b re=%b a=%h sz=%0d st=%0d", c,
                             lane_we, lane_re, a[g], sz[g], we[g]); end
                n_checks++;
                if ((we[g] ? w_addr : r_addr) !== exp_addrs(a[g], sz[g])) begin
                    n_errors++;
                    $display("FAIL rnd_addr c=%0d got %h exp %h", c,
                             we[g] ? w_addr : r_addr, exp_addrs(a[g], sz[g])); end
                if (we[g]) begin
                    n_checks++;
                    if (lane_din !== exp_din(a[g], sz[g], wd[g])) begin
                        n_errors++;
                        $display("FAIL rnd_din c=%0d got %h exp %h", c, lane_din,
                                 exp_din(a[g], sz[g], wd[g])); end
                end
            end else begin
                n_checks++; if (lane_we !== 4'h0 || lane_re !== 4'h0) begin n_errors++;
                    $display("FAIL rnd_idle c=%0d got we=%b re=%b", c, lane_we, lane_re); end
            end
            pend = acc && !we[g];
            if (pend) begin
                pend_port = g;
                pend_data = ref_load(a[g], sz[g], un[g]);
            end
            if (acc && we[g]) ref_store(a[g], sz[g], wd[g]);
            if (acc) model_last = g;
            tick();
        end
        clear_req();
        @(negedge CLK);
        n_checks++; if ({p1_rsp, p0_rsp} !== (pend ? (pend_port ? 2'b10 : 2'b01) : 2'b00)
                        || rdata !== (pend ? pend_data : 32'h0)) begin
            n_errors++;
            $display("FAIL rnd_rsp_last got v=%b d=%h exp d=%h", {p1_rsp, p0_rsp}, rdata,
                     pend_data); end
        tick();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'($urandom);
        test_reset();
        test_word_store();
        test_misaligned_half();
        test_fairness();
        test_wrap();
        test_size11();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
